// File: rtl/vector_issue_ctrl.sv
// vector_issue_ctrl: sequences 1..MAX_PASSES datapath passes per accepted
// vector instruction, delays vreg write strobes by RESULT_LATENCY and returns
// a one-cycle result-valid pulse to the core.
// Optional macro ISSUE_PERF_CNT_EN adds a saturating busy-cycle counter;
// without it perf_busy_cycles is tied to 0.
module vector_issue_ctrl #(
  parameter int MAX_PASSES     = 4,
  parameter int RESULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        apu_req,
  input  logic        op_vector,
  input  logic        op_writes_vreg,
  input  logic        op_widening,
  input  logic [4:0]  vl,
  input  logic [1:0]  vsew,
  output logic        apu_gnt,
  output logic        apu_rvalid,
  output logic        busy,
  output logic [1:0]  cycle_count,
  output logic [2:0]  word_count,
  output logic        vec_reg_write,
  output logic [31:0] perf_busy_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [4:0] MAXP = 5'(MAX_PASSES);

  state_t                    r_state;
  logic [1:0]                r_pass;
  logic [1:0]                r_last_idx;
  logic [2:0]                r_last_words;
  logic                      r_wvreg;
  logic [1:0]                r_drain;
  logic [RESULT_LATENCY-1:0] r_vld_pipe;

  logic [1:0]  w_sew;
  logic [2:0]  w_shift;
  logic [11:0] w_bits;
  logic [4:0]  w_passes;
  logic        w_clamp;
  logic [11:0] w_rem;
  logic [1:0]  w_last_idx;
  logic [2:0]  w_last_words;

  // Pass geometry from the request-time inputs; only latched on grant.
  always_comb begin
    w_sew        = (vsew == 2'd3) ? 2'd2 : vsew;
    w_shift      = 3'd3 + {1'b0, w_sew} + {2'b0, op_widening};
    w_bits       = 12'(vl) << w_shift;
    w_passes     = 5'((w_bits + 12'd127) >> 7);
    w_clamp      = (w_passes > MAXP);
    w_rem        = w_bits - {w_passes - 5'd1, 7'b0};
    w_last_idx   = w_clamp ? 2'(MAXP - 5'd1) : 2'(w_passes - 5'd1);
    w_last_words = w_clamp ? 3'd4 : 3'((w_rem + 12'd31) >> 5);
  end

  // Main sequencer: accept, issue passes, drain the write pipe, respond.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_pass       <= '0;
      r_last_idx   <= '0;
      r_last_words <= '0;
      r_wvreg      <= 1'b0;
      r_drain      <= '0;
    end else begin
      case (r_state)
        IDLE: if (apu_req) begin
          r_last_idx   <= w_last_idx;
          r_last_words <= w_last_words;
          r_wvreg      <= op_writes_vreg;
          r_pass       <= '0;
          r_state      <= (!op_vector || vl == 5'd0) ? RESP : ISSUE;
        end
        ISSUE: if (r_pass == r_last_idx) begin
          r_drain <= 2'(RESULT_LATENCY - 1);
          r_state <= DRAIN;
        end else begin
          r_pass <= r_pass + 2'd1;
        end
        DRAIN: if (r_drain == 2'd0) r_state <= RESP;
               else r_drain <= r_drain - 2'd1;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Issue-valid delay line matching the arithmetic stage depth.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= (r_state == ISSUE);
      for (int i = 1; i < RESULT_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign apu_gnt       = (r_state == IDLE) && apu_req;
  assign busy          = (r_state != IDLE);
  assign apu_rvalid    = (r_state == RESP);
  assign cycle_count   = (r_state == ISSUE) ? r_pass : 2'd0;
  assign word_count    = (r_state != ISSUE) ? 3'd0 :
                         (r_pass == r_last_idx) ? r_last_words : 3'd4;
  assign vec_reg_write = r_vld_pipe[RESULT_LATENCY-1] & r_wvreg;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] r_perf;
  // Saturating count of busy cycles, cleared only by reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                   r_perf <= '0;
    else if (busy && r_perf != '1)  r_perf <= r_perf + 32'd1;
  end
  assign perf_busy_cycles = r_perf;
`else
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Bench for vector_issue_ctrl: table of directed ops, hand-written held-request
// and mid-operation reset sequences, then random traffic, all compared every
// cycle against a timeline model of the instruction.
module tb_vector_issue_ctrl;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        n_reset, apu_req, op_vector, op_writes_vreg, op_widening;
  logic [4:0]  vl;
  logic [1:0]  vsew;
  logic        apu_gnt, apu_rvalid, busy, vec_reg_write;
  logic [1:0]  cycle_count;
  logic [2:0]  word_count;
  logic [31:0] perf_busy_cycles;

  vector_issue_ctrl #(.MAX_PASSES(4), .RESULT_LATENCY(L)) dut (
    .clk(clk), .n_reset(n_reset), .apu_req(apu_req), .op_vector(op_vector),
    .op_writes_vreg(op_writes_vreg), .op_widening(op_widening), .vl(vl),
    .vsew(vsew), .apu_gnt(apu_gnt), .apu_rvalid(apu_rvalid), .busy(busy),
    .cycle_count(cycle_count), .word_count(word_count),
    .vec_reg_write(vec_reg_write), .perf_busy_cycles(perf_busy_cycles));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Instruction timeline model: k = cycles since accept (1 = first busy cycle).
  bit     m_busy = 0, m_scalar = 0, m_wr = 0;
  int     m_k = 0, m_p = 0, m_end = 0;
  int     m_words[4];
  longint m_perf = 0;

  // Observations for the directed table.
  int obs_wr, obs_rv, obs_wc, c_rel;
  bit [7:0] obs_gnt;

  typedef struct {
    bit vec, wr, wide; int vl, sew; int exp_p, exp_wc, exp_rv;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_accept();
    int sewb, bits, praw;
    sewb = (vsew == 2'd3) ? 32 : (8 << vsew);
    bits = int'(vl) * sewb * (op_widening ? 2 : 1);
    m_wr = op_writes_vreg;
    if (!op_vector || vl == 0) begin
      m_scalar = 1; m_p = 0; m_end = 1;
    end else begin
      m_scalar = 0;
      praw = (bits + 127) / 128;
      if (praw > 4) begin
        m_p = 4;
        for (int i = 0; i < 4; i++) m_words[i] = 4;
      end else begin
        m_p = praw;
        for (int i = 0; i < 4; i++) m_words[i] = 4;
        m_words[m_p-1] = (bits - 128*(m_p-1) + 31) / 32;
      end
      m_end = m_p + L + 1;
    end
  endfunction

  task automatic m_edge();
    if (!n_reset) begin
      m_busy = 0; m_perf = 0;
    end else begin
      if (m_busy && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (!m_busy) begin
        if (apu_req) begin m_accept(); m_busy = 1; m_k = 1; end
      end else if (m_k == m_end) m_busy = 0;
      else m_k++;
    end
  endtask

  task automatic check_all(input string tag);
    bit iss;
    iss = m_busy && !m_scalar && m_k <= m_p;
    chk({tag, ".gnt"},    apu_gnt,    n_reset && !m_busy && apu_req);
    chk({tag, ".busy"},   busy,       m_busy);
    chk({tag, ".rvalid"}, apu_rvalid, m_busy && m_k == m_end);
    chk({tag, ".vwrite"}, vec_reg_write,
        m_busy && !m_scalar && m_wr && m_k >= 1+L && m_k <= m_p+L);
    if (iss) begin
      chk({tag, ".cycle_count"}, cycle_count, m_k - 1);
      chk({tag, ".word_count"},  word_count,  m_words[m_k-1]);
    end
`ifdef ISSUE_PERF_CNT_EN
    chk({tag, ".perf"}, perf_busy_cycles, m_perf);
`else
    chk({tag, ".perf"}, perf_busy_cycles, 0);
`endif
  endtask

  // Inputs are already driven; sample mid-cycle, then advance one clock.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    if (vec_reg_write) obs_wr++;
    if (apu_rvalid) obs_rv = c_rel;
    if (word_count != 0) obs_wc = word_count;
    if (apu_gnt && c_rel < 8) obs_gnt[c_rel] = 1'b1;
    c_rel++;
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic set_op(input bit v, input bit w, input bit wd, input int l, input int s);
    op_vector = v; op_writes_vreg = w; op_widening = wd;
    vl = 5'(l); vsew = 2'(s);
  endtask

  task automatic clr_obs();
    obs_wr = 0; obs_rv = -1; obs_wc = 0; c_rel = 0; obs_gnt = '0;
  endtask

  initial begin
    tbl[0]  = '{1,1,0, 4,2, 1,4,3};
    tbl[1]  = '{1,1,0,16,2, 4,4,6};
    tbl[2]  = '{1,1,1,10,1, 3,2,5};
    tbl[3]  = '{1,1,0, 0,2, 0,0,1};
    tbl[4]  = '{0,1,0, 8,2, 0,0,1};
    tbl[5]  = '{1,1,0,31,2, 4,4,6};
    tbl[6]  = '{1,1,0, 5,0, 1,2,3};
    tbl[7]  = '{1,1,0, 3,3, 1,3,3};
    tbl[8]  = '{1,1,0, 1,0, 1,1,3};
    tbl[9]  = '{1,1,0, 9,1, 2,1,4};
    tbl[10] = '{1,1,1,31,0, 4,4,6};
    tbl[11] = '{1,1,0,17,1, 3,1,5};

    n_reset = 0; apu_req = 0; set_op(0,0,0,0,0);
    @(negedge clk); @(negedge clk);
    cycle("reset");
    n_reset = 1;
    cycle("idle");

    // Directed table: one op per row, req for one cycle only.
    foreach (tbl[r]) begin
      clr_obs();
      set_op(tbl[r].vec, tbl[r].wr, tbl[r].wide, tbl[r].vl, tbl[r].sew);
      apu_req = 1;
      cycle($sformatf("row%0d", r));
      apu_req = 0;
      set_op(~tbl[r].vec, 0, ~tbl[r].wide, 7, 1);  // must be ignored while busy
      for (int c = 0; c < 8; c++) cycle($sformatf("row%0d", r));
      chk($sformatf("row%0d.writes", r),    obs_wr, tbl[r].exp_p);
      chk($sformatf("row%0d.rvalid_c", r),  obs_rv, tbl[r].exp_rv);
      if (tbl[r].exp_p != 0) chk($sformatf("row%0d.last_wc", r), obs_wc, tbl[r].exp_wc);
    end

    // Request held through a 1-pass op: grants only at c0 and c4.
    clr_obs();
    set_op(1,1,0,4,2); apu_req = 1;
    for (int c = 0; c < 6; c++) cycle("held");
    apu_req = 0;
    for (int c = 0; c < 6; c++) cycle("held");
    chk("held.gnt_mask", obs_gnt, 8'b0001_0001);
    chk("held.writes", obs_wr, 2);

`ifdef ISSUE_PERF_CNT_EN
    // Busy-cycle count over one 4-pass op from reset.
    n_reset = 0; #1; m_edge(); n_reset = 1;
    set_op(1,1,0,16,2); apu_req = 1; cycle("perf"); apu_req = 0;
    for (int c = 0; c < 8; c++) cycle("perf");
    chk("perf.case2", perf_busy_cycles, 6);
`endif

    // Reset asserted at c2 of a 4-pass op.
    clr_obs();
    set_op(1,1,0,16,2); apu_req = 1;
    cycle("rst"); apu_req = 0;
    cycle("rst");
    n_reset = 0;
    #1;
    chk("rst.busy_drop",   busy, 0);
    chk("rst.write_drop",  vec_reg_write, 0);
    chk("rst.rvalid_drop", apu_rvalid, 0);
    chk("rst.cc_drop",     cycle_count, 0);
    m_edge();
    @(negedge clk);
    cycle("rst_hold");
    n_reset = 1; apu_req = 1; set_op(1,1,0,4,2);
    #1; chk("rst.regrant", apu_gnt, 1);
    cycle("rst_after"); apu_req = 0;
    for (int c = 0; c < 5; c++) cycle("rst_after");

    // Random traffic, including input churn while busy.
    for (int n = 0; n < 400; n++) begin
      apu_req = ($urandom_range(0, 2) != 0);
      set_op($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 31), $urandom_range(0, 3));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if something above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
